dog_octave_engine: RTL and testbench

//  Streams one octave of NUM_SCALES Gaussian-blurred images from parallel BRAM read ports.

---
 rtl/dog_octave_engine_if.sv | 29 ++
 rtl/dog_octave_engine.sv | 120 ++++++++++++
 tb/tb_dog_octave_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dog_octave_engine_if.sv
// Bus between the DoG octave engine, the per-scale image BRAMs and the DoG output BRAMs.
interface dog_octave_engine_if #(
    parameter int DIMENSION  = 64,
    parameter int BIT_DEPTH  = 8,
    parameter int NUM_SCALES = 4
);
    localparam int AW = $clog2(DIMENSION * DIMENSION);
    localparam int OW = BIT_DEPTH + 1;

    logic                               start_in;
    logic [1:0]                         mode_in;
    logic [NUM_SCALES*BIT_DEPTH-1:0]    pix_in;
    logic [AW-1:0]                      read_addr_out;
    logic [AW-1:0]                      wr_addr_out;
    logic [(NUM_SCALES-1)*OW-1:0]       wr_data_out;
    logic                               wr_en_out;
    logic                               busy_out;
    logic                               done_out;

    modport master (
        output start_in, mode_in, pix_in,
        input  read_addr_out, wr_addr_out, wr_data_out, wr_en_out, busy_out, done_out
    );

    modport slave (
        input  start_in, mode_in, pix_in,
        output read_addr_out, wr_addr_out, wr_data_out, wr_en_out, busy_out, done_out
    );
endinterface

// File: rtl/dog_octave_engine.sv
// Streams one octave of blurred scales and writes all NUM_SCALES-1 DoG images in a single raster pass.
// Address-to-write latency BRAM_LATENCY+1; no backpressure, BRAMs and DoG writes are free-running.
module dog_octave_engine #(
    parameter int DIMENSION    = 64,
    parameter int BIT_DEPTH    = 8,
    parameter int NUM_SCALES   = 4,
    parameter int BRAM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_in,
    dog_octave_engine_if.slave bus
);
    localparam int NPIX = DIMENSION * DIMENSION;
    localparam int AW   = $clog2(NPIX);
    localparam int OW   = BIT_DEPTH + 1;
    localparam int ND   = NUM_SCALES - 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_ABS  = 2'd2;

    logic [1:0]              state;
    logic [1:0]              mode_q;
    logic [BRAM_LATENCY-1:0] vld_sr;
    logic [AW-1:0]           addr_sr [BRAM_LATENCY];
    logic [ND*OW-1:0]        dog_next;
    logic [OW-1:0]           diff;
    logic [OW-1:0]           mag;
    logic [OW-1:0]           field;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            mode_q            <= 2'd0;
            bus.read_addr_out <= '0;
            bus.busy_out      <= 1'b0;
            bus.done_out      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        state             <= READ;
                        mode_q            <= bus.mode_in;
                        bus.busy_out      <= 1'b1;
                        bus.read_addr_out <= '0;
                    end
                end
                READ: begin
                    if (bus.read_addr_out == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        bus.read_addr_out <= bus.read_addr_out + 1'b1;
                    end
                end
                DRAIN: begin
                    // Empty shift register here means the final write is on the bus this cycle.
                    if (vld_sr == '0) begin
                        state        <= DONE;
                        bus.done_out <= 1'b1;
                    end
                end
                default: begin
                    state             <= IDLE;
                    bus.done_out      <= 1'b0;
                    bus.busy_out      <= 1'b0;
                    bus.read_addr_out <= '0;
                end
            endcase
        end
    end

    // Sharper minus fuzzier per adjacent scale pair, then shaped by the latched mode.
    always_comb begin
        dog_next = '0;
        diff     = '0;
        mag      = '0;
        field    = '0;
        for (int k = 0; k < ND; k++) begin
            diff = {1'b0, bus.pix_in[k*BIT_DEPTH +: BIT_DEPTH]}
                 - {1'b0, bus.pix_in[(k+1)*BIT_DEPTH +: BIT_DEPTH]};
            mag  = diff[OW-1] ? (~diff + OW'(1)) : diff;
            case (mode_q)
                MODE_HALF: field = {diff[OW-1], diff[OW-1:1]};
                MODE_ABS:  field = mag[OW-1] ? {1'b0, {BIT_DEPTH{1'b1}}}
                                             : {1'b0, mag[BIT_DEPTH-1:0]};
                default:   field = diff;
            endcase
            dog_next[k*OW +: OW] = field;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            vld_sr          <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                addr_sr[i] <= '0;
            end
            bus.wr_en_out   <= 1'b0;
            bus.wr_addr_out <= '0;
            bus.wr_data_out <= '0;
        end else begin
            vld_sr[0]  <= (state == READ);
            addr_sr[0] <= bus.read_addr_out;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
            bus.wr_en_out <= vld_sr[BRAM_LATENCY-1];
            if (vld_sr[BRAM_LATENCY-1]) begin
                bus.wr_addr_out <= addr_sr[BRAM_LATENCY-1];
                bus.wr_data_out <= dog_next;
            end
        end
    end
endmodule

// File: tb/tb_dog_octave_engine.sv
// Scoreboard bench: a default-parameter engine plus a small DIMENSION=8, BRAM_LATENCY=1 engine.
module tb_dog_octave_engine;
    localparam int D_A = 64;
    localparam int L_A = 2;
    localparam int N_A = D_A * D_A;
    localparam int D_B = 8;
    localparam int L_B = 1;
    localparam int N_B = D_B * D_B;
    localparam int BD  = 8;
    localparam int S   = 4;

    typedef struct packed { logic [11:0] addr; logic [26:0] data; } exp_a_t;
    typedef struct packed { logic [5:0]  addr; logic [26:0] data; } exp_b_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    dog_octave_engine_if #(.DIMENSION(D_A), .BIT_DEPTH(BD), .NUM_SCALES(S)) bus_a ();
    dog_octave_engine_if #(.DIMENSION(D_B), .BIT_DEPTH(BD), .NUM_SCALES(S)) bus_b ();

    dog_octave_engine #(.DIMENSION(D_A), .BIT_DEPTH(BD), .NUM_SCALES(S), .BRAM_LATENCY(L_A))
        dut_a (.clk(clk), .rst_in(rst_a), .bus(bus_a));
    dog_octave_engine #(.DIMENSION(D_B), .BIT_DEPTH(BD), .NUM_SCALES(S), .BRAM_LATENCY(L_B))
        dut_b (.clk(clk), .rst_in(rst_b), .bus(bus_b));

    // Image content: 0 flat grey, 1 alternating 255/0 scales, 2 small table of pairs then a hash.
    function automatic int pix_of(input int pat, input int addr, input int k);
        logic [31:0] row;
        if (pat == 0) return 128;
        if (pat == 1) return (k % 2 == 0) ? 255 : 0;
        if (addr < 16) begin
            case (addr % 4)
                0:       row = 32'h03040A0D;
                1:       row = 32'h0D0A00FF;
                2:       row = 32'hFF00FF00;
                default: row = 32'h00FF8080;
            endcase
            return int'(row[31-8*k -: 8]);
        end
        return (addr * (k * 7 + 3) + k * 41 + (addr >> 5)) % 256;
    endfunction

    function automatic logic [26:0] exp_dog(input int pat, input int addr, input logic [1:0] mode);
        logic [26:0] res;
        int d, r;
        res = '0;
        for (int k = 0; k < S - 1; k++) begin
            d = pix_of(pat, addr, k) - pix_of(pat, addr, k + 1);
            case (mode)
                2'd1:    r = (d < 0) ? -((1 - d) / 2) : d / 2;
                2'd2:    begin r = (d < 0) ? -d : d; if (r > 255) r = 255; end
                default: r = d;
            endcase
            res[k*9 +: 9] = r[8:0];
        end
        return res;
    endfunction

    // BRAM models: registered address pipeline of the configured latency.
    int pat_a = 0;
    logic [11:0] apipe_a [L_A];
    logic [5:0]  apipe_b [L_B];
    always @(posedge clk) begin
        apipe_a[0] <= bus_a.read_addr_out;
        for (int i = 1; i < L_A; i++) apipe_a[i] <= apipe_a[i-1];
        apipe_b[0] <= bus_b.read_addr_out;
        for (int i = 1; i < L_B; i++) apipe_b[i] <= apipe_b[i-1];
    end
    always_comb begin
        bus_a.pix_in = '0;
        bus_b.pix_in = '0;
        for (int k = 0; k < S; k++) begin
            bus_a.pix_in[k*BD +: BD] = 8'(pix_of(pat_a, int'(apipe_a[L_A-1]), k));
            bus_b.pix_in[k*BD +: BD] = 8'(pix_of(2, int'(apipe_b[L_B-1]), k));
        end
    end

    exp_a_t sb_a[$];
    exp_b_t sb_b[$];
    exp_a_t ea;
    exp_b_t eb;
    int a_strobes, a_first, a_last, a_done_cnt, a_done_cyc;
    int a_err_addr, a_err_data, a_extra, a_hold, a_gap;
    logic [26:0] a_last_data = '0;
    logic [26:0] a_at [4];
    int b_strobes, b_first, b_last, b_err, b_done_cyc;

    always @(negedge clk) begin
        if (bus_a.wr_en_out) begin
            if (a_strobes == 0) a_first = cyc;
            else if (cyc != a_last + 1) a_gap++;
            a_last = cyc;
            a_strobes++;
            if (bus_a.wr_addr_out < 12'd4) a_at[bus_a.wr_addr_out[1:0]] = bus_a.wr_data_out;
            if (sb_a.size() == 0) a_extra++;
            else begin
                ea = sb_a.pop_front();
                if (ea.addr !== bus_a.wr_addr_out) a_err_addr++;
                if (ea.data !== bus_a.wr_data_out) a_err_data++;
            end
            a_last_data = bus_a.wr_data_out;
        end else if (rst_a) begin
            a_last_data = bus_a.wr_data_out;
        end else if (bus_a.wr_data_out !== a_last_data) begin
            a_hold++;
        end
        if (bus_a.done_out) begin a_done_cnt++; a_done_cyc = cyc; end
    end

    always @(negedge clk) begin
        if (bus_b.wr_en_out) begin
            if (b_strobes == 0) b_first = cyc;
            b_last = cyc;
            b_strobes++;
            if (sb_b.size() == 0) b_err++;
            else begin
                eb = sb_b.pop_front();
                if (eb.addr !== bus_b.wr_addr_out || eb.data !== bus_b.wr_data_out) b_err++;
            end
        end
        if (bus_b.done_out) b_done_cyc = cyc;
    end

    task automatic clear_a();
        a_strobes = 0; a_first = -1; a_last = -1; a_done_cnt = 0; a_done_cyc = -1;
        a_err_addr = 0; a_err_data = 0; a_extra = 0; a_hold = 0; a_gap = 0;
        for (int i = 0; i < 4; i++) a_at[i] = 'x;
    endtask

    task automatic start_a(input int pat, input logic [1:0] mode, output int s);
        exp_a_t e;
        for (int a = 0; a < N_A; a++) begin
            e.addr = 12'(a);
            e.data = exp_dog(pat, a, mode);
            sb_a.push_back(e);
        end
        pat_a = pat;
        @(posedge clk); #2;
        bus_a.mode_in = mode; bus_a.start_in = 1'b1; s = cyc;
        @(posedge clk); #2;
        bus_a.start_in = 1'b0; bus_a.mode_in = mode ^ 2'd1;
    endtask

    // extra=1 also pulses start mid-pass and during the DONE cycle.
    task automatic wait_done_a(input int extra, output int to);
        int base;
        base = cyc;
        to = 1;
        for (int i = 0; i < N_A + 100; i++) begin
            @(posedge clk); #2;
            bus_a.start_in = (extra != 0 && cyc == base + 1000);
            if (bus_a.done_out) begin to = 0; break; end
        end
        if (extra != 0 && to == 0) begin
            bus_a.start_in = 1'b1;
            @(posedge clk); #2;
            bus_a.start_in = 1'b0;
        end else begin
            bus_a.start_in = 1'b0;
            @(negedge clk); #1;
        end
    endtask

    task automatic start_b(output int s);
        exp_b_t e;
        for (int a = 0; a < N_B; a++) begin
            e.addr = 6'(a);
            e.data = exp_dog(2, a, 2'd0);
            sb_b.push_back(e);
        end
        @(posedge clk); #2;
        bus_b.mode_in = 2'd0; bus_b.start_in = 1'b1; s = cyc;
        @(posedge clk); #2;
        bus_b.start_in = 1'b0; bus_b.mode_in = 2'd2;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.start_in = 1'b0; bus_a.mode_in = 2'd0;
        bus_b.start_in = 1'b0; bus_b.mode_in = 2'd0;
        clear_a();
        b_strobes = 0; b_err = 0;
        #12;
        tests++;
        if ({bus_a.wr_en_out, bus_a.done_out, bus_a.busy_out, bus_a.wr_addr_out,
             bus_a.wr_data_out, bus_a.read_addr_out} !== '0) begin
            fails++; $display("FAIL reset_a: outputs %h, want 0", {bus_a.wr_en_out, bus_a.done_out,
                bus_a.busy_out, bus_a.wr_addr_out, bus_a.wr_data_out, bus_a.read_addr_out});
        end
        tests++;
        if ({bus_b.wr_en_out, bus_b.done_out, bus_b.busy_out, bus_b.wr_addr_out,
             bus_b.wr_data_out, bus_b.read_addr_out} !== '0) begin
            fails++; $display("FAIL reset_b: outputs not all zero");
        end
        @(posedge clk); #2;
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_equal_raw();
        int s, to;
        clear_a();
        start_a(0, 2'd0, s);
        wait_done_a(0, to);
        tests++; if (to !== 0) begin fails++; $display("FAIL equal_timeout: no done_out"); end
        tests++; if (a_strobes !== N_A) begin fails++; $display("FAIL equal_strobes: got %0d want %0d", a_strobes, N_A); end
        tests++; if (a_err_addr + a_err_data + a_extra + a_gap + a_hold !== 0) begin
            fails++; $display("FAIL equal_errors: addr %0d data %0d extra %0d gap %0d hold %0d want 0",
                a_err_addr, a_err_data, a_extra, a_gap, a_hold); end
        tests++; if (a_first !== s + L_A + 2) begin fails++; $display("FAIL equal_first: got %0d want %0d", a_first, s + L_A + 2); end
        tests++; if (a_done_cyc !== a_last + 1 || a_done_cnt !== 1) begin
            fails++; $display("FAIL equal_done: at %0d x%0d want %0d x1", a_done_cyc, a_done_cnt, a_last + 1); end
        tests++; if (a_last_data !== 27'd0) begin fails++; $display("FAIL equal_data: got %h want 0", a_last_data); end
    endtask

    task automatic test_raw();
        int s, to;
        clear_a();
        start_a(1, 2'd0, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A) begin fails++; $display("FAIL raw_strobes: got %0d want %0d", a_strobes, N_A); end
        tests++; if (a_err_addr + a_err_data + a_extra !== 0) begin fails++; $display("FAIL raw_errors: data %0d addr %0d want 0", a_err_data, a_err_addr); end
        tests++; if (a_last_data !== {9'h0FF, 9'h101, 9'h0FF}) begin fails++; $display("FAIL raw_value: got %h want %h", a_last_data, {9'h0FF, 9'h101, 9'h0FF}); end
    endtask

    task automatic test_modes();
        int s, to;
        clear_a();
        start_a(2, 2'd1, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A || a_err_data + a_err_addr !== 0) begin
            fails++; $display("FAIL half_pass: strobes %0d data errs %0d want %0d/0", a_strobes, a_err_data, N_A); end
        tests++; if (a_at[0] !== {9'h1FE, 9'h1FD, 9'h1FF}) begin fails++; $display("FAIL half_neg: got %h want %h", a_at[0], {9'h1FE, 9'h1FD, 9'h1FF}); end
        tests++; if (a_at[2] !== {9'h07F, 9'h180, 9'h07F}) begin fails++; $display("FAIL half_full: got %h want %h", a_at[2], {9'h07F, 9'h180, 9'h07F}); end
        clear_a();
        start_a(2, 2'd2, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A || a_err_data + a_err_addr !== 0) begin
            fails++; $display("FAIL abs_pass: strobes %0d data errs %0d want %0d/0", a_strobes, a_err_data, N_A); end
        tests++; if (a_at[0] !== {9'h003, 9'h006, 9'h001}) begin fails++; $display("FAIL abs_small: got %h want %h", a_at[0], {9'h003, 9'h006, 9'h001}); end
        tests++; if (a_at[1] !== {9'h0FF, 9'h00A, 9'h003}) begin fails++; $display("FAIL abs_full: got %h want %h", a_at[1], {9'h0FF, 9'h00A, 9'h003}); end
        clear_a();
        start_a(2, 2'd3, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A || a_err_data + a_err_addr !== 0) begin
            fails++; $display("FAIL reserved_pass: strobes %0d data errs %0d want %0d/0", a_strobes, a_err_data, N_A); end
    endtask

    task automatic test_start_ignored();
        int s, to;
        clear_a();
        start_a(1, 2'd0, s);
        wait_done_a(1, to);
        repeat (20) @(posedge clk);
        #2;
        tests++; if (to !== 0 || a_strobes !== N_A || a_done_cnt !== 1) begin
            fails++; $display("FAIL ignore_strobes: got %0d strobes %0d dones want %0d/1", a_strobes, a_done_cnt, N_A); end
        tests++; if (bus_a.busy_out !== 1'b0 || sb_a.size() !== 0) begin
            fails++; $display("FAIL ignore_idle: busy %b pending %0d want 0/0", bus_a.busy_out, sb_a.size()); end
    endtask

    task automatic test_back_to_back();
        int s, to;
        clear_a();
        start_a(2, 2'd0, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A || a_err_data + a_err_addr !== 0) begin
            fails++; $display("FAIL b2b_first: strobes %0d errs %0d want %0d/0", a_strobes, a_err_data + a_err_addr, N_A); end
        clear_a();
        start_a(1, 2'd1, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A || a_err_data + a_err_addr + a_extra !== 0) begin
            fails++; $display("FAIL b2b_second: strobes %0d errs %0d want %0d/0", a_strobes, a_err_data + a_err_addr, N_A); end
        tests++; if (a_first !== s + L_A + 2) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", a_first, s + L_A + 2); end
    endtask

    task automatic test_async_reset();
        int s, to;
        clear_a();
        start_a(2, 2'd0, s);
        repeat (500) @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        tests++;
        if ({bus_a.wr_en_out, bus_a.done_out, bus_a.busy_out, bus_a.wr_addr_out,
             bus_a.wr_data_out, bus_a.read_addr_out} !== '0) begin
            fails++; $display("FAIL arst_outputs: busy %b wr_en %b addr %0d want all 0",
                bus_a.busy_out, bus_a.wr_en_out, bus_a.read_addr_out); end
        sb_a.delete();
        repeat (3) @(posedge clk);
        clear_a();
        #2 rst_a = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        tests++; if (a_strobes !== 0 || bus_a.busy_out !== 1'b0) begin
            fails++; $display("FAIL arst_quiet: strobes %0d busy %b want 0/0", a_strobes, bus_a.busy_out); end
        clear_a();
        start_a(1, 2'd0, s);
        wait_done_a(0, to);
        tests++; if (to !== 0 || a_strobes !== N_A || a_err_data + a_err_addr + a_extra !== 0 || a_first !== s + L_A + 2) begin
            fails++; $display("FAIL arst_restart: strobes %0d errs %0d first %0d want %0d/0/%0d",
                a_strobes, a_err_data + a_err_addr, a_first, N_A, s + L_A + 2); end
    endtask

    task automatic test_param_b();
        int s, to;
        start_b(s);
        repeat (20) @(posedge clk);
        #3 rst_b = 1'b1;
        #1;
        tests++; if ({bus_b.wr_en_out, bus_b.busy_out, bus_b.read_addr_out, bus_b.wr_data_out} !== '0) begin
            fails++; $display("FAIL b_arst: busy %b wr_en %b want 0", bus_b.busy_out, bus_b.wr_en_out); end
        sb_b.delete();
        repeat (2) @(posedge clk);
        b_strobes = 0; b_err = 0; b_done_cyc = -1;
        #2 rst_b = 1'b0;
        repeat (10) @(posedge clk);
        tests++; if (b_strobes !== 0) begin fails++; $display("FAIL b_quiet: strobes %0d want 0", b_strobes); end
        start_b(s);
        to = 1;
        for (int i = 0; i < N_B + 50; i++) begin
            @(posedge clk); #2;
            if (bus_b.done_out) begin to = 0; break; end
        end
        @(negedge clk); #1;
        tests++; if (to !== 0 || b_strobes !== N_B || b_err !== 0) begin
            fails++; $display("FAIL b_pass: strobes %0d errs %0d want %0d/0", b_strobes, b_err, N_B); end
        tests++; if (b_first !== s + L_B + 2 || b_done_cyc !== b_last + 1) begin
            fails++; $display("FAIL b_timing: first %0d done %0d want %0d/%0d", b_first, b_done_cyc, s + L_B + 2, b_last + 1); end
    endtask

    initial begin
        test_reset();
        test_equal_raw();
        test_raw();
        test_modes();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_param_b();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
